// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl: load-use stall / taken-branch flush sequencer with statistics |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int OPC_W    = 7,
  parameter int LOAD_LAT = 1,
  parameter int BR_PEN   = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hazard_en,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic [OPC_W-1:0]  ex_opcode,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              busy,
  output logic [CNT_W-1:0]  load_stall_cnt,
  output logic [CNT_W-1:0]  br_flush_cnt
);

  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  // Remaining-cycle reload values; the first cycle is spent in IDLE.
  localparam logic [1:0] C_LD_REM = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;
  localparam logic [1:0] C_BR_REM = (BR_PEN > 1)   ? 2'(BR_PEN - 2)   : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LD_STALL = 2'd1,
    S_BR_FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         rem_q, rem_d;
  logic               busy_q;
  logic [CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic               stall_c, flush_if_id_c, flush_id_ex_c;

  logic is_load, is_branch, rs_match, ld_hit, br_hit;

  assign is_load   = (ex_opcode[6:0] == C_OPC_LOAD);
  assign is_branch = (ex_opcode[6:0] == C_OPC_BRANCH);
  assign rs_match  = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd));
  assign ld_hit    = hazard_en && ex_valid && id_valid && is_load &&
                     (ex_rd != '0) && rs_match;
  assign br_hit    = hazard_en && ex_valid && is_branch && ex_br_taken;

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    ld_cnt_d      = ld_cnt_q;
    br_cnt_d      = br_cnt_q;
    stall_c       = 1'b0;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (br_hit) begin
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
          if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
          if (BR_PEN > 1) begin
            state_d = S_BR_FLUSH;
            rem_d   = C_BR_REM;
          end
        end else if (ld_hit) begin
          stall_c       = 1'b1;
          flush_id_ex_c = 1'b1;
          if (ld_cnt_q != '1) ld_cnt_d = ld_cnt_q + 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = S_LD_STALL;
            rem_d   = C_LD_REM;
          end
        end
      end
      S_LD_STALL: begin
        stall_c       = 1'b1;
        flush_id_ex_c = 1'b1;
        if (rem_q == 2'd0) state_d = S_IDLE;
        else               rem_d   = rem_q - 2'd1;
      end
      S_BR_FLUSH: begin
        flush_if_id_c = 1'b1;
        flush_id_ex_c = 1'b1;
        if (rem_q == 2'd0) state_d = S_IDLE;
        else               rem_d   = rem_q - 2'd1;
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= 2'd0;
      busy_q   <= 1'b0;
      ld_cnt_q <= '0;
      br_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      busy_q   <= (state_d != S_IDLE);
      ld_cnt_q <= ld_cnt_d;
      br_cnt_q <= br_cnt_d;
    end
  end

  // The IDLE-cycle response is combinational, so gate it while reset is held.
  assign stall          = rst_n & stall_c;
  assign flush_if_id    = rst_n & flush_if_id_c;
  assign flush_id_ex    = rst_n & flush_id_ex_c;
  assign busy           = busy_q;
  assign load_stall_cnt = ld_cnt_q;
  assign br_flush_cnt   = br_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_ctrl: three parameterisations driven from shared stimulus        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam logic [6:0] LOAD = 7'b0000011;
  localparam logic [6:0] BRAN = 7'b1100011;

  typedef struct {
    logic       rst_n, en, idv;
    logic [4:0] rs1, rs2;
    logic       u1, u2, exv;
    logic [6:0] opc;
    logic [4:0] rd;
    logic       br;
  } in_t;

  typedef struct {
    in_t  in;
    logic st, fif, fie, busy;
    int   ldc, brc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, hazard_en, id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_br_taken;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [6:0] ex_opcode;

  logic        st_o[3], fif_o[3], fie_o[3], busy_o[3];
  logic [15:0] ldc_o[3], brc_o[3];
  logic [15:0] ldc_a, brc_a;
  logic [1:0]  ldc_b, brc_b;
  logic [3:0]  ldc_c, brc_c;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(3), .BR_PEN(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .hazard_en(hazard_en), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .stall(st_o[0]), .flush_if_id(fif_o[0]), .flush_id_ex(fie_o[0]), .busy(busy_o[0]),
    .load_stall_cnt(ldc_a), .br_flush_cnt(brc_a));

  hazard_ctrl #(.LOAD_LAT(1), .BR_PEN(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .hazard_en(hazard_en), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .stall(st_o[1]), .flush_if_id(fif_o[1]), .flush_id_ex(fie_o[1]), .busy(busy_o[1]),
    .load_stall_cnt(ldc_b), .br_flush_cnt(brc_b));

  hazard_ctrl #(.LOAD_LAT(4), .BR_PEN(3), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .hazard_en(hazard_en), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .stall(st_o[2]), .flush_if_id(fif_o[2]), .flush_id_ex(fie_o[2]), .busy(busy_o[2]),
    .load_stall_cnt(ldc_c), .br_flush_cnt(brc_c));

  assign ldc_o[0] = ldc_a;
  assign brc_o[0] = brc_a;
  assign ldc_o[1] = {14'd0, ldc_b};
  assign brc_o[1] = {14'd0, brc_b};
  assign ldc_o[2] = {12'd0, ldc_c};
  assign brc_o[2] = {12'd0, brc_c};

  // Reference model: each instance is either free, or owes 'left' more cycles
  // of the response it already started.
  int lat[3]  = '{3, 1, 4};
  int pen[3]  = '{2, 1, 3};
  int cmax[3] = '{65535, 3, 15};
  int left[3], m_ldc[3], m_brc[3];
  bit is_br[3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit_br();
    return hazard_en && ex_valid && ex_opcode == BRAN && ex_br_taken;
  endfunction

  function automatic bit hit_ld();
    bit m1 = id_use_rs1 && id_rs1 == ex_rd;
    bit m2 = id_use_rs2 && id_rs2 == ex_rd;
    return hazard_en && ex_valid && id_valid && ex_opcode == LOAD && ex_rd != 0 && (m1 || m2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      left[i] = 0; m_ldc[i] = 0; m_brc[i] = 0; is_br[i] = 1'b0;
    end
  endtask

  task automatic model_check();
    bit es, eif, eie, eb;
    if (!rst_n) model_reset();
    for (int i = 0; i < 3; i++) begin
      es = 0; eif = 0; eie = 0; eb = 0;
      if (rst_n) begin
        if (left[i] > 0) begin
          eb = 1; eie = 1;
          if (is_br[i]) eif = 1; else es = 1;
        end else if (hit_br()) begin
          eif = 1; eie = 1;
        end else if (hit_ld()) begin
          es = 1; eie = 1;
        end
      end
      chk($sformatf("m%0d.stall", i), int'(st_o[i]), int'(es));
      chk($sformatf("m%0d.flush_if_id", i), int'(fif_o[i]), int'(eif));
      chk($sformatf("m%0d.flush_id_ex", i), int'(fie_o[i]), int'(eie));
      chk($sformatf("m%0d.busy", i), int'(busy_o[i]), int'(eb));
      chk($sformatf("m%0d.load_stall_cnt", i), int'(ldc_o[i]), m_ldc[i]);
      chk($sformatf("m%0d.br_flush_cnt", i), int'(brc_o[i]), m_brc[i]);
    end
  endtask

  task automatic model_update();
    bit b = hit_br();
    bit l = hit_ld();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (left[i] > 0) left[i]--;
      else if (b) begin
        if (m_brc[i] < cmax[i]) m_brc[i]++;
        left[i] = pen[i] - 1; is_br[i] = 1'b1;
      end else if (l) begin
        if (m_ldc[i] < cmax[i]) m_ldc[i]++;
        left[i] = lat[i] - 1; is_br[i] = 1'b0;
      end
    end
  endtask

  task automatic drive(input in_t v);
    rst_n = v.rst_n; hazard_en = v.en; id_valid = v.idv;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_valid = v.exv; ex_opcode = v.opc; ex_rd = v.rd; ex_br_taken = v.br;
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 ns later.
  task automatic step(input in_t v);
    drive(v);
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic in_t mk(input bit en, input logic [6:0] opc, input logic [4:0] rd,
                             input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                             input bit u2, input bit br);
    in_t v;
    v.rst_n = 1'b1; v.en = en; v.idv = 1'b1; v.exv = 1'b1;
    v.opc = opc; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.br = br;
    return v;
  endfunction

  vec_t vt[15];
  in_t  ld_v, no_v, rs_v;

  initial begin
    ld_v = mk(1, LOAD, 5, 5, 1, 0, 0, 0);
    no_v = mk(1, 7'h13, 0, 0, 0, 0, 0, 0);
    // Expected values for the LOAD_LAT=3 / BR_PEN=2 instance.
    vt[0]  = '{no_v, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{ld_v, 1, 0, 1, 0, 0, 0};
    vt[2]  = '{no_v, 1, 0, 1, 1, 1, 0};
    vt[3]  = '{mk(0, LOAD, 5, 5, 1, 0, 0, 0), 1, 0, 1, 1, 1, 0};
    vt[4]  = '{no_v, 0, 0, 0, 0, 1, 0};
    vt[5]  = '{mk(1, LOAD, 0, 0, 1, 0, 1, 0), 0, 0, 0, 0, 1, 0};
    vt[6]  = '{mk(1, BRAN, 5, 5, 1, 0, 0, 1), 0, 1, 1, 0, 1, 0};
    vt[7]  = '{no_v, 0, 1, 1, 1, 1, 1};
    vt[8]  = '{no_v, 0, 0, 0, 0, 1, 1};
    vt[9]  = '{mk(1, BRAN, 5, 5, 1, 0, 0, 0), 0, 0, 0, 0, 1, 1};
    vt[10] = '{mk(1, LOAD, 5, 3, 0, 5, 1, 0), 1, 0, 1, 0, 1, 1};
    vt[11] = '{no_v, 1, 0, 1, 1, 2, 1};
    vt[12] = '{no_v, 1, 0, 1, 1, 2, 1};
    vt[13] = '{no_v, 0, 0, 0, 0, 2, 1};
    vt[14] = '{mk(0, LOAD, 5, 5, 1, 0, 0, 0), 0, 0, 0, 0, 2, 1};

    rs_v = no_v;
    rs_v.rst_n = 1'b0;
    drive(ld_v);
    rst_n = 1'b0;
    #1;
    chk("reset.stall", int'(st_o[0]), 0);
    chk("reset.flush_id_ex", int'(fie_o[0]), 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.busy", int'(busy_o[0]), 0);
    chk("reset.ld_cnt", int'(ldc_o[0]), 0);

    for (int k = 0; k < 15; k++) begin
      drive(vt[k].in);
      #1;
      chk($sformatf("vec%0d.stall", k), int'(st_o[0]), int'(vt[k].st));
      chk($sformatf("vec%0d.flush_if_id", k), int'(fif_o[0]), int'(vt[k].fif));
      chk($sformatf("vec%0d.flush_id_ex", k), int'(fie_o[0]), int'(vt[k].fie));
      chk($sformatf("vec%0d.busy", k), int'(busy_o[0]), int'(vt[k].busy));
      chk($sformatf("vec%0d.ld_cnt", k), int'(ldc_o[0]), vt[k].ldc);
      chk($sformatf("vec%0d.br_cnt", k), int'(brc_o[0]), vt[k].brc);
      model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
    end

    // Reset in the second stall cycle of the LOAD_LAT=4 instance.
    step(rs_v);
    step(no_v);
    step(ld_v);
    drive(no_v);
    #1;
    chk("rstmid.stall_before", int'(st_o[2]), 1);
    chk("rstmid.busy_before", int'(busy_o[2]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.stall", int'(st_o[2]), 0);
    chk("rstmid.flush_id_ex", int'(fie_o[2]), 0);
    chk("rstmid.busy", int'(busy_o[2]), 0);
    chk("rstmid.ld_cnt", int'(ldc_o[2]), 0);
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
    drive(no_v);
    #1;
    chk("rstmid.idle_stall", int'(st_o[2]), 0);
    chk("rstmid.idle_busy", int'(busy_o[2]), 0);
    @(negedge clk);

    // Saturation of the 2-bit counters, then a masked match.
    repeat (5) step(ld_v);
    step(no_v);
    step(no_v);
    step(no_v);
    drive(mk(0, LOAD, 5, 5, 1, 0, 0, 0));
    #1;
    chk("sat.ld_cnt", int'(ldc_o[1]), 3);
    chk("sat.masked_stall", int'(st_o[1]), 0);
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
    chk("sat.ld_cnt_after", int'(ldc_o[1]), 3);
    @(negedge clk);

    for (int k = 0; k < 400; k++) begin
      in_t v;
      int  sel;
      sel     = $urandom_range(0, 9);
      v.rst_n = ($urandom_range(0, 49) != 0);
      v.en    = ($urandom_range(0, 7) != 0);
      v.idv   = ($urandom_range(0, 7) != 0);
      v.exv   = ($urandom_range(0, 7) != 0);
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.rd    = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.br    = 1'($urandom_range(0, 1));
      v.opc   = (sel < 5) ? LOAD : (sel < 8) ? BRAN : 7'($urandom);
      step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter OPC_W, default 7, opcode width.
REQ-003 SHALL have parameter LOAD_LAT, default 1, legal 1..4, stall cycles per load-use hazard.
REQ-004 SHALL have parameter BR_PEN, default 2, legal 1..4, flush cycles per taken branch.
REQ-005 SHALL have parameter CNT_W, default 16, statistics-counter width.
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hazard_en  in  1  1 = new hazard detection enabled.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1, id_rs2  in  REG_AW  decode source registers.
- id_use_rs1, id_use_rs2  in  1  matching source operand is actually read.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_opcode  in  OPC_W  execute-stage opcode.
- ex_rd  in  REG_AW  execute-stage destination register.
- ex_br_taken  in  1  execute-stage branch resolved taken.
- stall  out  1  freeze PC and IF/ID register.
- flush_if_id  out  1  squash IF/ID contents.
- flush_id_ex  out  1  insert bubble into ID/EX.
- busy  out  1  state machine not in IDLE.
- load_stall_cnt  out  CNT_W  count of load-use hazards detected.
- br_flush_cnt  out  CNT_W  count of taken-branch flushes detected.

Function
REQ-007 SHALL decode LOAD as ex_opcode == 7'b0000011 and BRANCH as ex_opcode == 7'b1100011, compared in the low 7 bits.
REQ-008 SHALL define ld_hit = hazard_en & ex_valid & id_valid & LOAD & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-009 SHALL define br_hit = hazard_en & ex_valid & BRANCH & ex_br_taken.
REQ-010 SHALL implement a state machine with states IDLE, LD_STALL and BR_FLUSH, plus a 2-bit remaining-cycle counter rem.
REQ-011 In IDLE with br_hit, the block SHALL:
- assert flush_if_id and flush_id_ex combinationally in that cycle;
- if BR_PEN > 1, go to BR_FLUSH with rem = BR_PEN-2; otherwise stay in IDLE.
REQ-012 In IDLE with ld_hit and no br_hit, the block SHALL:
- assert stall and flush_id_ex combinationally in that cycle;
- if LOAD_LAT > 1, go to LD_STALL with rem = LOAD_LAT-2; otherwise stay in IDLE.
REQ-013 br_hit SHALL take priority over ld_hit when both are true in the same cycle; only br_flush_cnt increments in that cycle.
REQ-014 In LD_STALL, stall and flush_id_ex SHALL be 1; the block returns to IDLE when rem == 0, otherwise rem decrements.
REQ-015 In BR_FLUSH, flush_if_id and flush_id_ex SHALL be 1 and stall SHALL be 0; the block returns to IDLE when rem == 0, otherwise rem decrements.
REQ-016 In LD_STALL and BR_FLUSH, all inputs except rst_n SHALL be ignored, including hazard_en deassertion; an in-progress sequence always completes.
REQ-017 Total assertion lengths SHALL be exactly LOAD_LAT cycles for a load-use hazard and BR_PEN cycles for a taken branch.
REQ-018 busy SHALL equal (state != IDLE), registered.
REQ-019 load_stall_cnt SHALL increment by 1 on each IDLE-cycle ld_hit that is not overridden by br_hit.
REQ-020 br_flush_cnt SHALL increment by 1 on each IDLE-cycle br_hit.
REQ-021 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 With hazard_en = 0 in IDLE, stall, flush_if_id and flush_id_ex SHALL all be 0.

Reset
REQ-023 rst_n low SHALL asynchronously force state = IDLE, rem = 0, busy = 0 and both counters = 0.
REQ-024 While rst_n is low, stall, flush_if_id and flush_id_ex SHALL be 0 regardless of inputs.
REQ-025 A reset asserted mid-sequence SHALL abort the sequence; the first cycle after release is IDLE.

Verification
REQ-026 LOAD_LAT=1, ex LOAD rd=5, id rs1=5 use_rs1=1 -> stall=1 and flush_id_ex=1 for 1 cycle, busy stays 0, load_stall_cnt=1.
REQ-027 LOAD_LAT=3, same hazard -> stall=1 for exactly 3 cycles, busy=1 in cycles 2-3, then IDLE; ex_rd=0 -> no stall.
REQ-028 BR_PEN=2, ex BRANCH with br_taken=1 while a load-use match is also present -> flush_if_id=1 for 2 cycles, stall=0, br_flush_cnt=1, load_stall_cnt=0.
REQ-029 LOAD_LAT=4: rst_n pulsed low during the 2nd stall cycle -> outputs 0 immediately, counters 0, IDLE after release.
REQ-030 CNT_W=2: 5 load-use hazards -> load_stall_cnt reads 3 (saturated); hazard_en=0 with a match -> no stall and no increment.
